// File: rtl/sobel_edge_detect.sv
// Sobel edge detector: 3x3 window in, saturated |Gx|+|Gy| magnitude and thresholded edge bit out,
// tagged with column/row, fixed 3-cycle latency, no backpressure.
module sobel_edge_detect #(
  parameter int PIX_PER_LINE    = 320,
  parameter int LINES_PER_FRAME = 240
) (
  input  logic       clock,
  input  logic       frame_reset,
  input  logic [7:0] threshold,
  input  logic [7:0] data00,
  input  logic [7:0] data01,
  input  logic [7:0] data02,
  input  logic [7:0] data10,
  input  logic [7:0] data11,
  input  logic [7:0] data12,
  input  logic [7:0] data20,
  input  logic [7:0] data21,
  input  logic [7:0] data22,
  input  logic       data_valid,
  output logic [7:0] edge_mag,
  output logic       edge_bit,
  output logic       dataout_en,
  output logic [9:0] out_col,
  output logic [9:0] out_row,
  output logic       frame_done
);

  // Handshake: data_valid qualifies data00..22 for one cycle; dataout_en qualifies all result
  // outputs for one cycle, exactly 3 cycles later. There is no ready; every valid is accepted.

  localparam logic [9:0] LAST_COL = 10'(PIX_PER_LINE - 1);
  localparam logic [9:0] LAST_ROW = 10'(LINES_PER_FRAME - 3);

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
    return (p >= n) ? (p - n) : (n - p);
  endfunction

  // data11 is the window centre; Sobel kernels weight it by zero.
  logic unused_centre;
  assign unused_centre = ^data11;

  logic [9:0] col, row;
  logic [7:0] thr_q;

  logic       v1, border1;
  logic [9:0] gx_p1, gx_n1, gy_p1, gy_n1, col1, row1;

  logic       v2, border2;
  logic [9:0] ax2, ay2, col2, row2;

  logic [10:0] sum3;
  logic [7:0]  mag3;
  logic        bit3;

  // Stage 0: position counters and per-frame threshold capture
  always_ff @(posedge clock or posedge frame_reset) begin
    if (frame_reset) begin
      col   <= '0;
      row   <= '0;
      thr_q <= '0;
    end else if (data_valid) begin
      if (col == '0 && row == '0) thr_q <= threshold;
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // Stages 1 and 2: partial sums, then absolute gradients
  always_ff @(posedge clock or posedge frame_reset) begin
    if (frame_reset) begin
      v1 <= 1'b0; border1 <= 1'b0;
      gx_p1 <= '0; gx_n1 <= '0; gy_p1 <= '0; gy_n1 <= '0;
      col1 <= '0; row1 <= '0;
      v2 <= 1'b0; border2 <= 1'b0;
      ax2 <= '0; ay2 <= '0; col2 <= '0; row2 <= '0;
    end else begin
      v1      <= data_valid;
      border1 <= (col < 10'd2);
      gx_p1   <= wsum(data02, data12, data22);
      gx_n1   <= wsum(data00, data10, data20);
      gy_p1   <= wsum(data20, data21, data22);
      gy_n1   <= wsum(data00, data01, data02);
      col1    <= col;
      row1    <= row;
      v2      <= v1;
      border2 <= border1;
      ax2     <= absdiff(gx_p1, gx_n1);
      ay2     <= absdiff(gy_p1, gy_n1);
      col2    <= col1;
      row2    <= row1;
    end
  end

  // Stage 3 combinational: saturate, suppress the two border columns, threshold
  always_comb begin
    sum3 = {1'b0, ax2} + {1'b0, ay2};
    mag3 = (sum3 > 11'd255) ? 8'hff : sum3[7:0];
    bit3 = 1'b0;
    if (border2) mag3 = 8'h00;
    else         bit3 = (mag3 >= thr_q);
  end

  always_ff @(posedge clock or posedge frame_reset) begin
    if (frame_reset) begin
      edge_mag   <= '0;
      edge_bit   <= 1'b0;
      dataout_en <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      dataout_en <= v2;
      edge_mag   <= v2 ? mag3 : 8'h00;
      edge_bit   <= v2 & bit3;
      out_col    <= v2 ? col2 : 10'd0;
      out_row    <= v2 ? row2 : 10'd0;
      frame_done <= v2 && (col2 == LAST_COL) && (row2 == LAST_ROW);
    end
  end

endmodule
